// File: rtl/xgpon_burst_framer.sv
// Burst framer for the raw-mode PON TX stream: preamble, delimiter,
// buffered payload, optional trailer, then an idle guard gap.
module xgpon_burst_framer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 512,
    parameter int CNT_W      = 16
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    input  logic [CNT_W-1:0]      preamble_duration,
    input  logic [DATA_W-1:0]     preamble_pattern,
    input  logic [DATA_W-1:0]     delimiter_pattern,
    input  logic [DATA_W-1:0]     frtrail_pattern,
    input  logic                  trailer_en,
    input  logic [CNT_W-1:0]      guard_words,
    output logic                  busy,
    output logic                  underrun_err,
    output logic [CNT_W-1:0]      burst_count
);

    localparam int KW = DATA_W / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = DATA_W + KW + 2;
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      FONE    = 1;
    localparam logic [AW-1:0]    PONE    = 1;
    localparam logic [CNT_W-1:0] CONE    = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DELIM, S_DATA, S_TRAIL, S_GUARD
    } state_t;

    logic [FW-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_pop;
    logic [FW-1:0]     w_head;
    logic [DATA_W-1:0] w_h_data;
    logic [KW-1:0]     w_h_keep;
    logic              w_h_last;
    logic              w_h_user;
    logic [DATA_W-1:0] w_h_mask;

    state_t            r_state;
    state_t            w_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_uflag;
    logic [CNT_W-1:0]  r_burst;

    logic [CNT_W-1:0]  r_pre_dur;
    logic [DATA_W-1:0] r_pre_pat;
    logic [DATA_W-1:0] r_del_pat;
    logic [DATA_W-1:0] r_trl_pat;
    logic              r_trl_en;
    logic [CNT_W-1:0]  r_guard;

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [KW-1:0]     r_m_keep;
    logic              r_m_last;
    logic              r_m_user;

    logic              w_ld;
    logic              w_emit;
    logic [DATA_W-1:0] w_e_data;
    logic [KW-1:0]     w_e_keep;
    logic              w_e_last;
    logic              w_e_user;
    logic              w_start;
    logic              w_bump;
    logic              w_under;

    // Ready comes only from the registered occupancy; a same-cycle pop
    // does not open a slot for the writer.
    assign w_full        = (r_count == DEPTH_C);
    assign w_empty       = (r_count == '0);
    assign s_axis_tready = axis_resetn && !w_full;
    assign w_wr          = s_axis_tvalid && s_axis_tready;
    assign w_head        = r_mem[r_rd_ptr];
    assign w_h_data      = w_head[DATA_W-1:0];
    assign w_h_keep      = w_head[DATA_W +: KW];
    assign w_h_last      = w_head[FW-2];
    assign w_h_user      = w_head[FW-1];

    always_comb begin
        w_h_mask = '0;
        for (int i = 0; i < KW; i++) begin
            if (w_h_keep[i]) w_h_mask[8*i +: 8] = w_h_data[8*i +: 8];
        end
    end

    always_ff @(posedge axis_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {s_axis_tuser, s_axis_tlast,
                                s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PONE;
            if (w_wr && !w_pop) begin
                r_count <= r_count + FONE;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - FONE;
            end
        end
    end

    assign w_ld = !r_m_valid || m_axis_tready;

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_emit    = 1'b0;
        w_e_data  = '0;
        w_e_keep  = '0;
        w_e_last  = 1'b0;
        w_e_user  = 1'b0;
        w_pop     = 1'b0;
        w_start   = 1'b0;
        w_bump    = 1'b0;
        w_under   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable && !w_empty) begin
                    w_start   = 1'b1;
                    w_cnt_nxt = '0;
                    w_nxt     = (preamble_duration != '0) ? S_PRE : S_DELIM;
                end
            end
            S_PRE: begin
                if (w_ld) begin
                    w_emit   = 1'b1;
                    w_e_data = r_pre_pat;
                    w_e_keep = '1;
                    if (r_cnt == r_pre_dur - CONE) begin
                        w_cnt_nxt = '0;
                        w_nxt     = S_DELIM;
                    end else begin
                        w_cnt_nxt = r_cnt + CONE;
                    end
                end
            end
            S_DELIM: begin
                if (w_ld) begin
                    w_emit   = 1'b1;
                    w_e_data = r_del_pat;
                    w_e_keep = '1;
                    w_nxt    = S_DATA;
                end
            end
            S_DATA: begin
                if (w_empty) begin
                    w_under = !r_uflag;
                end else if (w_ld) begin
                    w_pop    = 1'b1;
                    w_emit   = 1'b1;
                    w_e_data = w_h_mask;
                    w_e_keep = w_h_keep;
                    w_e_user = w_h_user;
                    w_e_last = w_h_last && !r_trl_en;
                    if (w_h_last) begin
                        w_nxt  = r_trl_en ? S_TRAIL : S_GUARD;
                        w_bump = !r_trl_en;
                    end
                end
            end
            S_TRAIL: begin
                if (w_ld) begin
                    w_emit   = 1'b1;
                    w_e_data = r_trl_pat;
                    w_e_keep = '1;
                    w_e_last = 1'b1;
                    w_bump   = 1'b1;
                    w_nxt    = S_GUARD;
                end
            end
            S_GUARD: begin
                // Guard cycles count only once the last word has left.
                if (!r_m_valid) begin
                    if (r_guard == '0 || r_cnt == r_guard - CONE) begin
                        w_cnt_nxt = '0;
                        w_nxt     = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CONE;
                    end
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_uflag   <= 1'b0;
            r_burst   <= '0;
            r_pre_dur <= '0;
            r_pre_pat <= '0;
            r_del_pat <= '0;
            r_trl_pat <= '0;
            r_trl_en  <= 1'b0;
            r_guard   <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_under) begin
                r_uflag <= 1'b1;
            end else if (w_pop || w_start) begin
                r_uflag <= 1'b0;
            end
            if (w_bump) r_burst <= r_burst + CONE;
            if (w_start) begin
                r_pre_dur <= preamble_duration;
                r_pre_pat <= preamble_pattern;
                r_del_pat <= delimiter_pattern;
                r_trl_pat <= frtrail_pattern;
                r_trl_en  <= trailer_en;
                r_guard   <= guard_words;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
        end else if (w_ld) begin
            r_m_valid <= w_emit;
            if (w_emit) begin
                r_m_data <= w_e_data;
                r_m_keep <= w_e_keep;
                r_m_last <= w_e_last;
                r_m_user <= w_e_user;
            end
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tkeep  = r_m_keep;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tuser  = r_m_user;
    assign busy          = (r_state != S_IDLE);
    assign underrun_err  = w_under;
    assign burst_count   = r_burst;

endmodule

// File: doc/xgpon_burst_framer.md
Name: xgpon_burst_framer

Overview:
- Parametrised burst framer for the GTH raw-mode PON datapath. Wraps each AXI-Stream frame as: preamble words, one delimiter word, payload, optional frame-trailer word, then a programmable idle guard gap.
- Replaces the fixed-delay-line approach with an input FIFO, full valid/ready backpressure, runtime-configurable patterns and explicit error reporting.
- Sits between the Ethernet/XGEM source and the transceiver TX stream.

Parameters:
DATA_W, 32, stream data width in bits; multiple of 8, range 16..128
FIFO_DEPTH, 512, input FIFO depth in words; power of 2, must exceed the maximum preamble_duration+2
CNT_W, 16, width of the preamble/guard counters and burst_count

Ports:
axis_clk  in  1  single clock
axis_resetn  in  1  synchronous, active-low reset
enable  in  1  allows a new burst to start; sampled only in IDLE
s_axis_tdata  in  DATA_W  payload
s_axis_tkeep  in  DATA_W/8  byte enables; contiguous from LSB
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  last payload beat of frame
s_axis_tuser  in  1  sideband, passed through with its beat
s_axis_tready  out  1  high when FIFO not full
m_axis_tdata  out  DATA_W  framed output
m_axis_tkeep  out  DATA_W/8  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last word of burst
m_axis_tuser  out  1  sideband
m_axis_tready  in  1  downstream ready
preamble_duration  in  CNT_W  number of preamble words; 0 = none
preamble_pattern  in  DATA_W  preamble word
delimiter_pattern  in  DATA_W  delimiter word
frtrail_pattern  in  DATA_W  trailer word
trailer_en  in  1  append trailer word when 1
guard_words  in  CNT_W  idle cycles enforced after each burst
busy  out  1  FSM not in IDLE
underrun_err  out  1  one-cycle pulse per underrun
burst_count  out  CNT_W  completed bursts; wraps

Behaviour:
- Reset (axis_resetn=0 at a clock edge) → FSM=IDLE, FIFO emptied, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=0 during reset, busy=0, underrun_err=0, burst_count=0.
- Reset mid-burst aborts immediately: no trailer is sent, and FIFO contents are discarded.
- Input side: a beat is written on s_axis_tvalid&&s_axis_tready. s_axis_tready = !fifo_full.
- Output is a registered stage:
  - a word is transferred on m_axis_tvalid&&m_axis_tready;
  - while m_axis_tvalid=1 and m_axis_tready=0, tdata/tkeep/tlast/tuser must hold stable.
- All counters advance only on output transfers.
- Config capture: preamble_duration, all three patterns, trailer_en and guard_words are latched on the IDLE→start transition. Changes mid-burst have no effect.
- FSM states:
  - IDLE: if enable && FIFO not empty → PREAMBLE when preamble_duration>0, else DELIM.
  - PREAMBLE: emit preamble_pattern, tkeep all-ones, tuser=0. Go to DELIM after preamble_duration transfers.
  - DELIM: emit delimiter_pattern once → DATA.
  - DATA: pop the FIFO and emit payload.
    - Bytes with tkeep=0 are forced to 0x00 in tdata.
    - tuser is passed through.
    - On the transfer of the tlast beat → TRAILER if trailer_en, else GUARD.
  - TRAILER: emit frtrail_pattern, tkeep all-ones, tuser=0 → GUARD.
  - GUARD: m_axis_tvalid=0 for guard_words cycles (0 = skip) → IDLE. burst_count increments on entry to GUARD.
- m_axis_tlast: asserted on the trailer word when trailer_en=1, otherwise on the final payload beat. It is never asserted on preamble or delimiter words.
- Latency: with an empty FIFO, enable=1 and m_axis_tready=1, the first preamble word is valid on m_axis two clocks after the first input handshake.
- Underrun: in DATA with the FIFO empty before tlast has been seen:
  - m_axis_tvalid=0;
  - underrun_err pulses on the first empty cycle only;
  - the FSM waits in DATA. No fill words are inserted.
- enable deasserted mid-burst: the burst completes normally, and the FSM then stays in IDLE.
- Simultaneous FIFO write and read when full: the read frees a slot, but tready stays computed from the registered full flag; no bypass.
- Back-to-back frames: the next burst begins only after GUARD completes.

Test Plan:
- Basic framing: DATA_W=32, preamble_duration=3, pattern 0x05560556, delimiter 0xB2C50FA1, trailer 0x82D6F416, trailer_en=1, guard_words=2, 4-beat frame, last tkeep=0x3 → output is 3×0x05560556, 0xB2C50FA1, 4 payload words with last word masked to 0x0000xxxx, 0x82D6F416 with tlast; then ≥2 idle cycles; burst_count=1.
- Backpressure: same frame with m_axis_tready toggling 1,0,0,1 repeatedly → identical word sequence; data stable while stalled; no words lost or duplicated.
- preamble_duration=0, trailer_en=0 → delimiter is the first word; tlast lands on the final payload beat; no trailer.
- Underrun: input stalls for 5 cycles mid-frame → exactly one underrun_err pulse; output resumes with the correct next word.
- FIFO full: m_axis_tready=0, 600 input beats offered → s_axis_tready drops after 512 accepted beats; all data is delivered in order once released.
- Reset mid-PREAMBLE, then a new frame → all outputs are zero in the reset cycle; the new burst is framed cleanly from preamble word 1.
